// File: rtl/vexriscv_axi_rd_arbiter.sv
// Two-to-one AXI4 read arbiter for the VexRiscv imem/dmem ports; dmem writes pass straight through.
// Optional `ARB_DMEM_PRIORITY_EN`: contested grants always go to dmem instead of round-robin.
module vexriscv_axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic [ID_WIDTH-1:0]     s_imem_arid,
    input  logic [ADDR_WIDTH-1:0]   s_imem_araddr,
    input  logic [7:0]              s_imem_arlen,
    input  logic [2:0]              s_imem_arsize,
    input  logic [1:0]              s_imem_arburst,
    input  logic                    s_imem_arlock,
    input  logic [3:0]              s_imem_arcache,
    input  logic [2:0]              s_imem_arprot,
    input  logic [3:0]              s_imem_arqos,
    input  logic                    s_imem_arvalid,
    output logic                    s_imem_arready,
    output logic [ID_WIDTH-1:0]     s_imem_rid,
    output logic [DATA_WIDTH-1:0]   s_imem_rdata,
    output logic [1:0]              s_imem_rresp,
    output logic                    s_imem_rlast,
    output logic                    s_imem_rvalid,
    input  logic                    s_imem_rready,

    input  logic [ID_WIDTH-1:0]     s_dmem_arid,
    input  logic [ADDR_WIDTH-1:0]   s_dmem_araddr,
    input  logic [7:0]              s_dmem_arlen,
    input  logic [2:0]              s_dmem_arsize,
    input  logic [1:0]              s_dmem_arburst,
    input  logic                    s_dmem_arlock,
    input  logic [3:0]              s_dmem_arcache,
    input  logic [2:0]              s_dmem_arprot,
    input  logic [3:0]              s_dmem_arqos,
    input  logic                    s_dmem_arvalid,
    output logic                    s_dmem_arready,
    output logic [ID_WIDTH-1:0]     s_dmem_rid,
    output logic [DATA_WIDTH-1:0]   s_dmem_rdata,
    output logic [1:0]              s_dmem_rresp,
    output logic                    s_dmem_rlast,
    output logic                    s_dmem_rvalid,
    input  logic                    s_dmem_rready,

    input  logic [ID_WIDTH-1:0]     s_dmem_awid,
    input  logic [ADDR_WIDTH-1:0]   s_dmem_awaddr,
    input  logic [7:0]              s_dmem_awlen,
    input  logic [2:0]              s_dmem_awsize,
    input  logic [1:0]              s_dmem_awburst,
    input  logic                    s_dmem_awlock,
    input  logic [3:0]              s_dmem_awcache,
    input  logic [2:0]              s_dmem_awprot,
    input  logic [3:0]              s_dmem_awqos,
    input  logic                    s_dmem_awvalid,
    output logic                    s_dmem_awready,
    input  logic [DATA_WIDTH-1:0]   s_dmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_dmem_wstrb,
    input  logic                    s_dmem_wlast,
    input  logic                    s_dmem_wvalid,
    output logic                    s_dmem_wready,
    output logic [ID_WIDTH-1:0]     s_dmem_bid,
    output logic [1:0]              s_dmem_bresp,
    output logic                    s_dmem_bvalid,
    input  logic                    s_dmem_bready,

    output logic [ID_WIDTH:0]       m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arlock,
    output logic [3:0]              m_arcache,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arqos,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH:0]       m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [ID_WIDTH:0]       m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awqos,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH:0]       m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_ptr_q, rr_ptr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (s_imem_arvalid && s_dmem_arvalid) begin
`ifdef ARB_DMEM_PRIORITY_EN
                    owner_d  = 1'b1;
`else
                    owner_d  = rr_ptr_q;
                    rr_ptr_d = ~rr_ptr_q;
`endif
                    state_d  = S_ADDR;
                end else if (s_imem_arvalid) begin
                    owner_d = 1'b0;
                    state_d = S_ADDR;
                end else if (s_dmem_arvalid) begin
                    owner_d = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: if (m_arvalid && m_arready) state_d = S_DATA;
            S_DATA: if (m_rvalid && m_rready && m_rlast) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake gating only; payloads below are muxed from owner unconditionally.
    always_comb begin
        m_arvalid      = 1'b0;
        s_imem_arready = 1'b0;
        s_dmem_arready = 1'b0;
        m_rready       = 1'b0;
        s_imem_rvalid  = 1'b0;
        s_dmem_rvalid  = 1'b0;
        busy           = (state_q != S_IDLE);
        case (state_q)
            S_ADDR: begin
                m_arvalid = owner_q ? s_dmem_arvalid : s_imem_arvalid;
                if (owner_q) s_dmem_arready = m_arready;
                else         s_imem_arready = m_arready;
            end
            S_DATA: begin
                m_rready      = owner_q ? s_dmem_rready : s_imem_rready;
                s_imem_rvalid = m_rvalid & ~owner_q;
                s_dmem_rvalid = m_rvalid &  owner_q;
            end
            default: ;
        endcase
    end

    assign m_arid    = owner_q ? {1'b1, s_dmem_arid} : {1'b0, s_imem_arid};
    assign m_araddr  = owner_q ? s_dmem_araddr  : s_imem_araddr;
    assign m_arlen   = owner_q ? s_dmem_arlen   : s_imem_arlen;
    assign m_arsize  = owner_q ? s_dmem_arsize  : s_imem_arsize;
    assign m_arburst = owner_q ? s_dmem_arburst : s_imem_arburst;
    assign m_arlock  = owner_q ? s_dmem_arlock  : s_imem_arlock;
    assign m_arcache = owner_q ? s_dmem_arcache : s_imem_arcache;
    assign m_arprot  = owner_q ? s_dmem_arprot  : s_imem_arprot;
    assign m_arqos   = owner_q ? s_dmem_arqos   : s_imem_arqos;

    assign s_imem_rid   = m_rid[ID_WIDTH-1:0];
    assign s_imem_rdata = m_rdata;
    assign s_imem_rresp = m_rresp;
    assign s_imem_rlast = m_rlast;
    assign s_dmem_rid   = m_rid[ID_WIDTH-1:0];
    assign s_dmem_rdata = m_rdata;
    assign s_dmem_rresp = m_rresp;
    assign s_dmem_rlast = m_rlast;

    // dmem is the only writer, so the write ID prefix is fixed at 1.
    assign m_awid         = {1'b1, s_dmem_awid};
    assign m_awaddr       = s_dmem_awaddr;
    assign m_awlen        = s_dmem_awlen;
    assign m_awsize       = s_dmem_awsize;
    assign m_awburst      = s_dmem_awburst;
    assign m_awlock       = s_dmem_awlock;
    assign m_awcache      = s_dmem_awcache;
    assign m_awprot       = s_dmem_awprot;
    assign m_awqos        = s_dmem_awqos;
    assign m_awvalid      = s_dmem_awvalid;
    assign s_dmem_awready = m_awready;
    assign m_wdata        = s_dmem_wdata;
    assign m_wstrb        = s_dmem_wstrb;
    assign m_wlast        = s_dmem_wlast;
    assign m_wvalid       = s_dmem_wvalid;
    assign s_dmem_wready  = m_wready;
    assign s_dmem_bid     = m_bid[ID_WIDTH-1:0];
    assign s_dmem_bresp   = m_bresp;
    assign s_dmem_bvalid  = m_bvalid;
    assign m_bready       = s_dmem_bready;

    logic unused_id_msb;
    assign unused_id_msb = m_rid[ID_WIDTH] ^ m_bid[ID_WIDTH];

endmodule

// File: tb/tb_vexriscv_axi_rd_arbiter.sv
// Self-checking bench for vexriscv_axi_rd_arbiter: write pass-through vector table plus
// scoreboarded read bursts against a simple single-outstanding AXI slave model.
`timescale 1ns/1ps
module tb_vexriscv_axi_rd_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [0:0]  s_imem_arid = '0, s_dmem_arid = '0, s_dmem_awid = '0;
    logic [31:0] s_imem_araddr = '0, s_dmem_araddr = '0, s_dmem_awaddr = '0, s_dmem_wdata = '0;
    logic [7:0]  s_imem_arlen = '0, s_dmem_arlen = '0, s_dmem_awlen = 8'd0;
    logic [2:0]  s_imem_arsize = 3'd2, s_dmem_arsize = 3'd2, s_dmem_awsize = 3'd2;
    logic [1:0]  s_imem_arburst = 2'd1, s_dmem_arburst = 2'd1, s_dmem_awburst = 2'd1;
    logic        s_imem_arlock = 1'b0, s_dmem_arlock = 1'b0, s_dmem_awlock = 1'b0;
    logic [3:0]  s_imem_arcache = 4'h2, s_dmem_arcache = 4'h3, s_dmem_awcache = 4'h3;
    logic [2:0]  s_imem_arprot = 3'b100, s_dmem_arprot = 3'b000, s_dmem_awprot = 3'b001;
    logic [3:0]  s_imem_arqos = 4'h0, s_dmem_arqos = 4'h1, s_dmem_awqos = 4'h0;
    logic        s_imem_arvalid = 1'b0, s_dmem_arvalid = 1'b0;
    logic        s_imem_rready = 1'b1, s_dmem_rready = 1'b1;
    logic [3:0]  s_dmem_wstrb = '0;
    logic        s_dmem_wlast = 1'b1, s_dmem_awvalid = 1'b0, s_dmem_wvalid = 1'b0, s_dmem_bready = 1'b0;
    logic        m_arready = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [1:0]  m_bid = '0, m_bresp = '0;

    logic        s_imem_arready, s_dmem_arready, s_imem_rvalid, s_dmem_rvalid;
    logic [0:0]  s_imem_rid, s_dmem_rid, s_dmem_bid;
    logic [31:0] s_imem_rdata, s_dmem_rdata;
    logic [1:0]  s_imem_rresp, s_dmem_rresp, s_dmem_bresp;
    logic        s_imem_rlast, s_dmem_rlast, s_dmem_awready, s_dmem_wready, s_dmem_bvalid;
    logic [1:0]  m_arid, m_awid, m_rid;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
    logic [1:0]  m_arburst, m_awburst, m_rresp;
    logic        m_arlock, m_awlock, m_arvalid, m_awvalid, m_wlast, m_wvalid, m_bready;
    logic [3:0]  m_arcache, m_arqos, m_awcache, m_awqos, m_wstrb;
    logic        m_rlast, m_rvalid, m_rready, busy;

    // slave model state
    logic        slv_active = 1'b0;
    logic [31:0] slv_addr = '0;
    logic [7:0]  slv_len = '0, slv_beat = '0;
    logic [1:0]  slv_id = '0;
    logic        force_rv = 1'b0;
    logic        rr_toggle = 1'b0;
    int          ar_stall = 0;

    function automatic logic [31:0] data_of(input logic [31:0] addr, input logic [7:0] beat);
        return addr + 32'(beat) * 32'h0100_0001;
    endfunction

    assign m_rvalid = slv_active | force_rv;
    assign m_rdata  = data_of(slv_addr, slv_beat);
    assign m_rlast  = slv_active && (slv_beat == slv_len);
    assign m_rid    = slv_id;
    assign m_rresp  = 2'b00;

    vexriscv_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
        .clk(clk), .resetn(resetn),
        .s_imem_arid(s_imem_arid), .s_imem_araddr(s_imem_araddr), .s_imem_arlen(s_imem_arlen),
        .s_imem_arsize(s_imem_arsize), .s_imem_arburst(s_imem_arburst), .s_imem_arlock(s_imem_arlock),
        .s_imem_arcache(s_imem_arcache), .s_imem_arprot(s_imem_arprot), .s_imem_arqos(s_imem_arqos),
        .s_imem_arvalid(s_imem_arvalid), .s_imem_arready(s_imem_arready),
        .s_imem_rid(s_imem_rid), .s_imem_rdata(s_imem_rdata), .s_imem_rresp(s_imem_rresp),
        .s_imem_rlast(s_imem_rlast), .s_imem_rvalid(s_imem_rvalid), .s_imem_rready(s_imem_rready),
        .s_dmem_arid(s_dmem_arid), .s_dmem_araddr(s_dmem_araddr), .s_dmem_arlen(s_dmem_arlen),
        .s_dmem_arsize(s_dmem_arsize), .s_dmem_arburst(s_dmem_arburst), .s_dmem_arlock(s_dmem_arlock),
        .s_dmem_arcache(s_dmem_arcache), .s_dmem_arprot(s_dmem_arprot), .s_dmem_arqos(s_dmem_arqos),
        .s_dmem_arvalid(s_dmem_arvalid), .s_dmem_arready(s_dmem_arready),
        .s_dmem_rid(s_dmem_rid), .s_dmem_rdata(s_dmem_rdata), .s_dmem_rresp(s_dmem_rresp),
        .s_dmem_rlast(s_dmem_rlast), .s_dmem_rvalid(s_dmem_rvalid), .s_dmem_rready(s_dmem_rready),
        .s_dmem_awid(s_dmem_awid), .s_dmem_awaddr(s_dmem_awaddr), .s_dmem_awlen(s_dmem_awlen),
        .s_dmem_awsize(s_dmem_awsize), .s_dmem_awburst(s_dmem_awburst), .s_dmem_awlock(s_dmem_awlock),
        .s_dmem_awcache(s_dmem_awcache), .s_dmem_awprot(s_dmem_awprot), .s_dmem_awqos(s_dmem_awqos),
        .s_dmem_awvalid(s_dmem_awvalid), .s_dmem_awready(s_dmem_awready),
        .s_dmem_wdata(s_dmem_wdata), .s_dmem_wstrb(s_dmem_wstrb), .s_dmem_wlast(s_dmem_wlast),
        .s_dmem_wvalid(s_dmem_wvalid), .s_dmem_wready(s_dmem_wready),
        .s_dmem_bid(s_dmem_bid), .s_dmem_bresp(s_dmem_bresp), .s_dmem_bvalid(s_dmem_bvalid),
        .s_dmem_bready(s_dmem_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // scoreboard
    typedef struct {logic port; logic [31:0] addr; logic [7:0] len;} ar_exp_t;
    typedef struct {logic port; logic [31:0] data; logic last;} r_exp_t;
    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int imem_beats = 0;
    int stall_cycles = 0;

    task automatic pop_r(input logic port, input logic [31:0] data, input logic last,
                         input logic [1:0] resp, input logic [0:0] id);
        r_exp_t e;
        if (r_q.size() == 0) fail("r_unexpected_beat");
        else begin
            e = r_q.pop_front();
            check("r_beat", {port, last, resp, id, data}, {e.port, e.last, 2'b00, 1'b0, e.data});
        end
    endtask

    initial begin : monitor
        ar_exp_t     e;
        r_exp_t      r;
        logic        hold_v;
        logic [39:0] hold_pl;
        hold_v = 1'b0;
        hold_pl = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (s_imem_rvalid || s_dmem_rvalid)
                    check("r_exclusive", s_imem_rvalid & s_dmem_rvalid, 0);
                if (hold_v && m_arvalid) check("ar_payload_stable", {m_araddr, m_arlen}, hold_pl);
                hold_v  = m_arvalid && !m_arready;
                hold_pl = {m_araddr, m_arlen};
                if (hold_v) stall_cycles++;
                if (m_arvalid && m_arready) begin
                    if (ar_q.size() == 0) fail("ar_unexpected");
                    else begin
                        e = ar_q.pop_front();
                        check("ar_grant", {m_arid, m_araddr, m_arlen}, {e.port, 1'b0, e.addr, e.len});
                        for (int b = 0; b <= int'(e.len); b++) begin
                            r.port = e.port;
                            r.data = data_of(e.addr, 8'(b));
                            r.last = (b == int'(e.len));
                            r_q.push_back(r);
                        end
                    end
                end
                if (s_imem_rvalid && s_imem_rready) begin
                    pop_r(1'b0, s_imem_rdata, s_imem_rlast, s_imem_rresp, s_imem_rid);
                    imem_beats++;
                end
                if (s_dmem_rvalid && s_dmem_rready)
                    pop_r(1'b1, s_dmem_rdata, s_dmem_rlast, s_dmem_rresp, s_dmem_rid);
            end
        end
    end

    // slave + requester handshake model; acts 1 ns after each rising edge
    initial begin : bfm
        logic ar_fire, r_fire, i_fire, d_fire, rst_seen;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        logic [1:0]  cap_id;
        forever begin
            @(negedge clk);
            ar_fire  = m_arvalid & m_arready;
            r_fire   = m_rvalid & m_rready & slv_active;
            i_fire   = s_imem_arvalid & s_imem_arready;
            d_fire   = s_dmem_arvalid & s_dmem_arready;
            cap_addr = m_araddr;
            cap_len  = m_arlen;
            cap_id   = m_arid;
            rst_seen = !resetn;
            @(posedge clk);
            #1;
            rst_seen = rst_seen | !resetn;
            if (i_fire) s_imem_arvalid = 1'b0;
            if (d_fire) s_dmem_arvalid = 1'b0;
            if (rst_seen) slv_active = 1'b0;
            else begin
                if (r_fire) begin
                    if (slv_beat == slv_len) slv_active = 1'b0;
                    else slv_beat = slv_beat + 8'd1;
                end
                if (ar_fire) begin
                    slv_active = 1'b1;
                    slv_addr   = cap_addr;
                    slv_len    = cap_len;
                    slv_beat   = 8'd0;
                    slv_id     = cap_id;
                end
            end
            if (ar_stall > 0) begin
                m_arready = 1'b0;
                if (m_arvalid) ar_stall--;
            end else m_arready = 1'b1;
            if (rr_toggle) begin
                s_imem_rready = ~s_imem_rready;
                s_dmem_rready = ~s_dmem_rready;
            end else begin
                s_imem_rready = 1'b1;
                s_dmem_rready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ar(input logic port, input logic [31:0] addr, input logic [7:0] len);
        ar_exp_t e;
        if (!port) begin
            s_imem_araddr = addr; s_imem_arlen = len; s_imem_arvalid = 1'b1;
        end else begin
            s_dmem_araddr = addr; s_dmem_arlen = len; s_dmem_arvalid = 1'b1;
        end
    endtask

    task automatic expect_ar(input logic port, input logic [31:0] addr, input logic [7:0] len);
        ar_exp_t e;
        e.port = port; e.addr = addr; e.len = len;
        ar_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy || ar_q.size() != 0 || r_q.size() != 0 || s_imem_arvalid || s_dmem_arvalid) && n < 300);
        check({name, "_timeout"}, n >= 300, 0);
        check({name, "_idle_outs"}, {busy, m_arvalid, m_rready, s_imem_rvalid, s_dmem_rvalid,
                                     s_imem_arready, s_dmem_arready}, 0);
    endtask

    typedef struct {
        logic        frv;
        logic        v;
        logic [0:0]  awid;
        logic [31:0] awaddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bid;
        logic [1:0]  bresp;
        logic [1:0]  exp_awid;
        logic [0:0]  exp_bid;
    } vec_t;
    vec_t vecs[4];

    task automatic apply_wr(input vec_t v, input string name);
        s_dmem_awid = v.awid; s_dmem_awaddr = v.awaddr; s_dmem_wdata = v.wdata;
        s_dmem_wstrb = v.wstrb; m_bid = v.bid; m_bresp = v.bresp;
        s_dmem_awvalid = v.v; s_dmem_wvalid = v.v; m_bvalid = v.v;
        m_awready = v.v; m_wready = v.v; s_dmem_bready = v.v;
        #1;
        check({name, "_ids"}, {m_awid, s_dmem_bid, s_dmem_bresp}, {v.exp_awid, v.exp_bid, v.bresp});
        check({name, "_payload"}, {m_awaddr, m_wdata, m_wstrb}, {v.awaddr, v.wdata, v.wstrb});
        check({name, "_handshake"}, {m_awvalid, m_wvalid, s_dmem_bvalid, s_dmem_awready, s_dmem_wready, m_bready},
              {6{v.v}});
        check({name, "_attr"}, {m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_wlast},
              {8'd0, 3'd2, 2'd1, 1'b0, 4'h3, 3'b001, 4'h0, 1'b1});
    endtask

    logic first_grant[3];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : test
        int base, n;
        vecs[0] = '{frv: 1'b0, v: 1'b1, awid: 1'b0, awaddr: 32'h0000_1000, wdata: 32'hDEAD_BEEF,
                    wstrb: 4'hF, bid: 2'b10, bresp: 2'b00, exp_awid: 2'b10, exp_bid: 1'b0};
        vecs[1] = '{frv: 1'b1, v: 1'b1, awid: 1'b1, awaddr: 32'h2000_0004, wdata: 32'h1234_5678,
                    wstrb: 4'h3, bid: 2'b11, bresp: 2'b10, exp_awid: 2'b11, exp_bid: 1'b1};
        vecs[2] = '{frv: 1'b1, v: 1'b0, awid: 1'b0, awaddr: 32'hFFFF_FFFC, wdata: 32'h0000_0000,
                    wstrb: 4'h0, bid: 2'b01, bresp: 2'b11, exp_awid: 2'b10, exp_bid: 1'b1};
        vecs[3] = '{frv: 1'b0, v: 1'b1, awid: 1'b1, awaddr: 32'h0000_0000, wdata: 32'h0000_A5A5,
                    wstrb: 4'h8, bid: 2'b00, bresp: 2'b01, exp_awid: 2'b11, exp_bid: 1'b0};
`ifdef ARB_DMEM_PRIORITY_EN
        first_grant = '{1'b1, 1'b1, 1'b1};
`else
        first_grant = '{1'b0, 1'b1, 1'b0};
`endif

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_outs", {busy, m_arvalid, s_imem_arready, s_dmem_arready, s_imem_rvalid, s_dmem_rvalid, m_rready}, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("post_rst_idle", {busy, m_arvalid, m_rready}, 0);

        // write pass-through vectors, with spurious m_rvalid in IDLE
        for (int i = 0; i < 4; i++) begin
            tick();
            force_rv = vecs[i].frv;
            apply_wr(vecs[i], $sformatf("wr_vec%0d", i));
            check($sformatf("idle_rv_ignored%0d", i), {m_rready, s_imem_rvalid, s_dmem_rvalid, busy}, 0);
        end
        tick();
        force_rv = 1'b0;

        // single imem burst with latency check
        expect_ar(1'b0, 32'h8000_0000, 8'd7);
        drive_ar(1'b0, 32'h8000_0000, 8'd7);
        #1;
        check("lat_same_cycle", m_arvalid, 0);
        tick();
        check("lat_next_cycle", {m_arvalid, m_arid, busy, s_dmem_arready}, {1'b1, 2'b00, 1'b1, 1'b0});
        check("ar_attr_imem", {m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos},
              {3'd2, 2'd1, 1'b0, 4'h2, 3'b100, 4'h0});
        wait_idle("imem_burst");
        check("imem_beats", imem_beats, 8);

        // contested rounds
        for (int r = 0; r < 3; r++) begin
            expect_ar(first_grant[r], 32'h0001_0000 + 32'(r) * 32'h100, 8'd3);
            expect_ar(~first_grant[r], 32'h0002_0000 + 32'(r) * 32'h100, 8'd3);
            if (first_grant[r]) begin
                drive_ar(1'b1, 32'h0001_0000 + 32'(r) * 32'h100, 8'd3);
                drive_ar(1'b0, 32'h0002_0000 + 32'(r) * 32'h100, 8'd3);
            end else begin
                drive_ar(1'b0, 32'h0001_0000 + 32'(r) * 32'h100, 8'd3);
                drive_ar(1'b1, 32'h0002_0000 + 32'(r) * 32'h100, 8'd3);
            end
            tick();
            check($sformatf("tie%0d_owner", r), {m_arid[1], first_grant[r] ? s_imem_arready : s_dmem_arready},
                  {first_grant[r], 1'b0});
            wait_idle($sformatf("tie%0d", r));
        end

        // AR backpressure plus toggling rready
        ar_stall = 5;
        rr_toggle = 1'b1;
        stall_cycles = 0;
        expect_ar(1'b1, 32'h0000_4000, 8'd3);
        drive_ar(1'b1, 32'h0000_4000, 8'd3);
        wait_idle("backpressure");
        check("stall_seen", stall_cycles >= 5, 1);
        rr_toggle = 1'b0;

        // write during an imem read
        expect_ar(1'b0, 32'h8000_0100, 8'd7);
        drive_ar(1'b0, 32'h8000_0100, 8'd7);
        repeat (4) tick();
        check("wr_during_read_busy", busy, 1);
        apply_wr(vecs[0], "wr_mid_read");
        wait_idle("read_with_write");

        // reset on beat 3 of 8
        base = imem_beats;
        expect_ar(1'b0, 32'h8000_0200, 8'd7);
        drive_ar(1'b0, 32'h8000_0200, 8'd7);
        n = 0;
        while (imem_beats < base + 2 && n < 100) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", n >= 100, 0);
        check("rst_pre_rvalid", s_imem_rvalid, 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_outs", {m_arvalid, s_imem_rvalid, s_dmem_rvalid, m_rready, busy}, 0);
        repeat (2) tick();
        ar_q.delete();
        r_q.delete();
        resetn = 1'b1;
        tick();
        expect_ar(1'b1, 32'h0000_8000, 8'd1);
        drive_ar(1'b1, 32'h0000_8000, 8'd1);
        tick();
        check("post_rst_grant", {m_arvalid, m_arid}, {1'b1, 2'b10});
        wait_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
